// File: rtl/complex_div_pkg.sv
// rtl/complex_div_pkg.sv - shared types and widths for the sequential complex divider
package complex_div_pkg;

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

  localparam int OPW  = 8;
  localparam int OUTW = 16;
  localparam int NUMW = 17;
  localparam int DENW = 16;

  localparam logic signed [OUTW-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [OUTW-1:0] Q_MIN = 16'sh8000;

endpackage

// File: rtl/serial_udiv.sv
// rtl/serial_udiv.sv - unsigned restoring divider, one quotient bit per step
module serial_udiv #(
  parameter int W  = 23,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [W-1:0]  i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic [W-1:0]  o_quot,
  output logic [DW-1:0] o_rem
);

  logic [W-1:0]  r_q;
  logic [DW-1:0] r_r;
  logic [DW:0]   w_sh;
  logic [DW-1:0] w_diff;
  logic          w_ge;

  // Partial remainder stays below the divisor, so DW bits hold it between steps.
  assign w_sh   = {r_r, r_q[W-1]};
  assign w_ge   = (w_sh >= {1'b0, i_divisor});
  assign w_diff = w_sh[DW-1:0] - i_divisor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      r_r <= '0;
    end else if (i_load) begin
      r_q <= i_dividend;
      r_r <= '0;
    end else if (i_step) begin
      r_q <= {r_q[W-2:0], w_ge};
      r_r <= w_ge ? w_diff : w_sh[DW-1:0];
    end
  end

  assign o_quot = r_q;
  assign o_rem  = r_r;

endmodule

// File: rtl/complex_divider.sv
// rtl/complex_divider.sv - sequential fixed-point complex divider q = n*conj(d)/|d|^2
// Optional: define COMPLEX_DIV_ROUND_EN to round half away from zero instead of truncating.
module complex_divider
  import complex_div_pkg::*;
#(
  parameter int FRAC_BITS = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [OPW-1:0]  n_real,
  input  logic signed [OPW-1:0]  n_imag,
  input  logic signed [OPW-1:0]  d_real,
  input  logic signed [OPW-1:0]  d_imag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [OUTW-1:0] q_real,
  output logic signed [OUTW-1:0] q_imag,
  output logic                   div_by_zero,
  output logic                   saturated
);

  localparam int ITER = 16 + FRAC_BITS;
  localparam int CNTW = $clog2(ITER);
  localparam logic [ITER:0] MAG_POS_MAX = (ITER+1)'(32767);
  localparam logic [ITER:0] MAG_NEG_MAX = (ITER+1)'(32768);

  state_t                 r_state;
  logic signed [OPW-1:0]  r_nr, r_ni, r_dr, r_di;
  logic [DENW-1:0]        r_den;
  logic                   r_neg_re, r_neg_im;
  logic [CNTW-1:0]        r_cnt;
  logic                   r_in_ready, r_out_valid, r_dbz, r_sat;
  logic signed [OUTW-1:0] r_q_re, r_q_im;

  logic signed [NUMW-1:0] w_num_re, w_num_im;
  logic [NUMW-1:0]        w_mag_re, w_mag_im;
  logic [DENW-1:0]        w_den;
  logic [ITER-1:0]        w_dvd_re, w_dvd_im, w_quot_re, w_quot_im;
  logic [DENW-1:0]        w_rem_re, w_rem_im;
  logic                   w_rnd_re, w_rnd_im, w_load, w_step;
  logic [ITER:0]          w_mfin_re, w_mfin_im;
  logic [OUTW:0]          w_res_re, w_res_im;

  function automatic logic [OUTW:0] apply_sign(input logic neg, input logic [ITER:0] mag);
    logic [OUTW-1:0] m16;
    if (!neg && mag > MAG_POS_MAX) return {1'b1, Q_MAX};
    if (neg && mag > MAG_NEG_MAX) return {1'b1, Q_MIN};
    m16 = mag[OUTW-1:0];
    return {1'b0, neg ? -m16 : m16};
  endfunction

  // n*conj(d): real = nr*dr + ni*di, imag = ni*dr - nr*di
  assign w_num_re = NUMW'(r_nr) * NUMW'(r_dr) + NUMW'(r_ni) * NUMW'(r_di);
  assign w_num_im = NUMW'(r_ni) * NUMW'(r_dr) - NUMW'(r_nr) * NUMW'(r_di);
  assign w_den    = DENW'(NUMW'(r_dr) * NUMW'(r_dr) + NUMW'(r_di) * NUMW'(r_di));
  assign w_mag_re = w_num_re[NUMW-1] ? -w_num_re : w_num_re;
  assign w_mag_im = w_num_im[NUMW-1] ? -w_num_im : w_num_im;
  assign w_dvd_re = ITER'(w_mag_re) << FRAC_BITS;
  assign w_dvd_im = ITER'(w_mag_im) << FRAC_BITS;
  assign w_load   = (r_state == PREP) && (w_den != '0);
  assign w_step   = (r_state == DIV);

  serial_udiv #(.W(ITER), .DW(DENW)) u_div_re (
    .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step),
    .i_dividend(w_dvd_re), .i_divisor(r_den), .o_quot(w_quot_re), .o_rem(w_rem_re)
  );

  serial_udiv #(.W(ITER), .DW(DENW)) u_div_im (
    .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step),
    .i_dividend(w_dvd_im), .i_divisor(r_den), .o_quot(w_quot_im), .o_rem(w_rem_im)
  );

`ifdef COMPLEX_DIV_ROUND_EN
  assign w_rnd_re = ({w_rem_re, 1'b0} >= {1'b0, r_den});
  assign w_rnd_im = ({w_rem_im, 1'b0} >= {1'b0, r_den});
`else
  logic w_unused_rem;
  assign w_unused_rem = ^{w_rem_re, w_rem_im};
  assign w_rnd_re     = 1'b0;
  assign w_rnd_im     = 1'b0;
`endif

  assign w_mfin_re = {1'b0, w_quot_re} + (ITER+1)'(w_rnd_re);
  assign w_mfin_im = {1'b0, w_quot_im} + (ITER+1)'(w_rnd_im);
  assign w_res_re  = apply_sign(r_neg_re, w_mfin_re);
  assign w_res_im  = apply_sign(r_neg_im, w_mfin_im);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q_re      <= '0;
      r_q_im      <= '0;
      r_dbz       <= 1'b0;
      r_sat       <= 1'b0;
      r_cnt       <= '0;
      r_nr        <= '0;
      r_ni        <= '0;
      r_dr        <= '0;
      r_di        <= '0;
      r_den       <= '0;
      r_neg_re    <= 1'b0;
      r_neg_im    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_nr       <= n_real;
          r_ni       <= n_imag;
          r_dr       <= d_real;
          r_di       <= d_imag;
          r_in_ready <= 1'b0;
          r_state    <= PREP;
        end
        PREP: begin
          r_den    <= w_den;
          r_neg_re <= w_num_re[NUMW-1];
          r_neg_im <= w_num_im[NUMW-1];
          r_cnt    <= '0;
          r_state  <= (w_den == '0) ? FIX : DIV;
        end
        DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNTW'(ITER - 1)) r_state <= FIX;
        end
        FIX: begin
          if (r_den == '0) begin
            r_q_re <= '0;
            r_q_im <= '0;
            r_dbz  <= 1'b1;
            r_sat  <= 1'b0;
          end else begin
            r_q_re <= w_res_re[OUTW-1:0];
            r_q_im <= w_res_im[OUTW-1:0];
            r_dbz  <= 1'b0;
            r_sat  <= w_res_re[OUTW] | w_res_im[OUTW];
          end
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign q_real      = r_q_re;
  assign q_imag      = r_q_im;
  assign div_by_zero = r_dbz;
  assign saturated   = r_sat;

endmodule

// File: tb/tb_complex_divider.sv
// tb/tb_complex_divider.sv - scoreboard bench for complex_divider at FRAC_BITS 7 and 8
module tb_complex_divider;

  typedef struct packed {
    logic signed [15:0] q_re;
    logic signed [15:0] q_im;
    logic               dbz;
    logic               sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid  [2];
  logic              in_ready  [2];
  logic signed [7:0] n_real    [2];
  logic signed [7:0] n_imag    [2];
  logic signed [7:0] d_real    [2];
  logic signed [7:0] d_imag    [2];
  logic              out_valid [2];
  logic              out_ready [2];
  logic signed [15:0] q_real   [2];
  logic signed [15:0] q_imag   [2];
  logic              dbz       [2];
  logic              sat       [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  complex_divider #(.FRAC_BITS(7)) u_dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .n_real(n_real[0]), .n_imag(n_imag[0]), .d_real(d_real[0]), .d_imag(d_imag[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .q_real(q_real[0]), .q_imag(q_imag[0]),
    .div_by_zero(dbz[0]), .saturated(sat[0])
  );

  complex_divider #(.FRAC_BITS(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .n_real(n_real[1]), .n_imag(n_imag[1]), .d_real(d_real[1]), .d_imag(d_imag[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .q_real(q_real[1]), .q_imag(q_imag[1]),
    .div_by_zero(dbz[1]), .saturated(sat[1])
  );

  function automatic int comp_ref(input int num, input int den, input int frac);
    int mag, q, r;
    mag = (num < 0 ? -num : num) * (1 << frac);
    q = mag / den;
    r = mag % den;
`ifdef COMPLEX_DIV_ROUND_EN
    if (2 * r >= den) q = q + 1;
`endif
    return (num < 0) ? -q : q;
  endfunction

  function automatic exp_t model(input int frac, input int nr, input int ni, input int dr, input int di);
    exp_t e;
    int a, b, den, va, vb;
    a = nr * dr + ni * di;
    b = ni * dr - nr * di;
    den = dr * dr + di * di;
    e.dbz = (den == 0);
    e.sat = 1'b0;
    e.q_re = '0;
    e.q_im = '0;
    if (den != 0) begin
      va = comp_ref(a, den, frac);
      vb = comp_ref(b, den, frac);
      if (va > 32767) begin va = 32767; e.sat = 1'b1; end
      if (va < -32768) begin va = -32768; e.sat = 1'b1; end
      if (vb > 32767) begin vb = 32767; e.sat = 1'b1; end
      if (vb < -32768) begin vb = -32768; e.sat = 1'b1; end
      e.q_re = 16'(va);
      e.q_im = 16'(vb);
    end
    return e;
  endfunction

  // Scoreboard: every accepted result is popped and compared on its handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst && out_valid[k] && out_ready[k]) begin
        exp_t e;
        n_cmp++;
        if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
          n_err++;
          $display("FAIL sb_empty dut%0d: got re=%0d im=%0d with no expected entry", k, q_real[k], q_imag[k]);
        end else begin
          e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
          if ({q_real[k], q_imag[k], dbz[k], sat[k]} !== e) begin
            n_err++;
            $display("FAIL sb_result dut%0d: got re=%0d im=%0d dbz=%b sat=%b, want re=%0d im=%0d dbz=%b sat=%b",
                     k, q_real[k], q_imag[k], dbz[k], sat[k], e.q_re, e.q_im, e.dbz, e.sat);
          end
        end
      end
    end
  end

  task automatic send(input int k, input int nr, input int ni, input int dr, input int di);
    int w = 0;
    exp_t e = model((k == 0) ? 7 : 8, nr, ni, dr, di);
    if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    n_real[k] = 8'(nr);
    n_imag[k] = 8'(ni);
    d_real[k] = 8'(dr);
    d_imag[k] = 8'(di);
    in_valid[k] = 1'b1;
    while (!in_ready[k] && w < 200) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (!out_valid[k] && n < 200) begin @(posedge clk); #1; n++; end
  endtask

  task automatic ack(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hs dut%0d: got in_ready=%b out_valid=%b, want 1 0", k, in_ready[k], out_valid[k]);
      end
      n_cmp++;
      if (q_real[k] !== 16'sd0 || q_imag[k] !== 16'sd0 || dbz[k] !== 1'b0 || sat[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_out dut%0d: got re=%0d im=%0d dbz=%b sat=%b, want all 0", k, q_real[k], q_imag[k], dbz[k], sat[k]);
      end
    end
  endtask

  task automatic test_basic;
    int ops [4][4] = '{'{8, 0, 2, 0}, '{1, 1, 1, -1}, '{1, 0, 3, 0}, '{-100, 37, 5, -9}};
    int n, nr, ni, dr, di, lat;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        nr = ops[i][0]; ni = ops[i][1]; dr = ops[i][2]; di = ops[i][3];
      end else begin
        nr = int'($urandom_range(0, 255)) - 128;
        ni = int'($urandom_range(0, 255)) - 128;
        dr = int'($urandom_range(0, 255)) - 128;
        di = int'($urandom_range(0, 255)) - 128;
      end
      lat = (dr == 0 && di == 0) ? 2 : 25;
      send(0, nr, ni, dr, di);
      wait_valid(0, n);
      n_cmp++;
      if (n !== lat) begin
        n_err++;
        $display("FAIL basic_latency op%0d: got %0d edges, want %0d", i, n, lat);
      end
      ack(0);
    end
  endtask

  task automatic test_dbz;
    int n;
    send(0, 5, -7, 0, 0);
    wait_valid(0, n);
    n_cmp++;
    if (n !== 2) begin
      n_err++;
      $display("FAIL dbz_latency: got %0d edges, want 2", n);
    end
    n_cmp++;
    if (dbz[0] !== 1'b1) begin
      n_err++;
      $display("FAIL dbz_flag: got %b, want 1", dbz[0]);
    end
    ack(0);
  endtask

  task automatic test_stall;
    int n;
    exp_t e;
    send(0, 7, -3, 2, 5);
    wait_valid(0, n);
    n_cmp++;
    if (n !== 25) begin
      n_err++;
      $display("FAIL stall_latency: got %0d edges, want 25", n);
    end
    e = (sb0.size() > 0) ? sb0[0] : '0;
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = (i % 2 == 0);
      n_real[0] = 8'(i * 13);
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || q_real[0] !== e.q_re || q_imag[0] !== e.q_im) begin
        n_err++;
        $display("FAIL stall_hold cyc%0d: got ov=%b ir=%b re=%0d im=%0d, want ov=1 ir=0 re=%0d im=%0d",
                 i, out_valid[0], in_ready[0], q_real[0], q_imag[0], e.q_re, e.q_im);
      end
    end
    in_valid[0] = 1'b0;
    ack(0);
    n_cmp++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: got in_ready=%b out_valid=%b, want 1 0", in_ready[0], out_valid[0]);
    end
    send(0, -50, 20, -3, 4);
    wait_valid(0, n);
    n_cmp++;
    if (n !== 25) begin
      n_err++;
      $display("FAIL stall_next_latency: got %0d edges, want 25", n);
    end
    ack(0);
  endtask

  task automatic test_saturate;
    int ops [4][4] = '{'{-128, 0, -1, 0}, '{-128, 0, 1, 0}, '{1, 0, 3, 0}, '{127, -128, -128, 127}};
    int n;
    for (int i = 0; i < 4; i++) begin
      send(1, ops[i][0], ops[i][1], ops[i][2], ops[i][3]);
      wait_valid(1, n);
      n_cmp++;
      if (n !== 26) begin
        n_err++;
        $display("FAIL sat_latency op%0d: got %0d edges, want 26", i, n);
      end
      ack(1);
    end
  endtask

  task automatic test_midreset;
    int n;
    send(0, 9, 4, -2, 3);
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || q_real[0] !== 16'sd0 || q_imag[0] !== 16'sd0) begin
      n_err++;
      $display("FAIL midreset_async: got ir=%b ov=%b re=%0d im=%0d, want 1 0 0 0", in_ready[0], out_valid[0], q_real[0], q_imag[0]);
    end
    if (sb0.size() > 0) void'(sb0.pop_back());
    @(negedge clk) rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid[0] !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_discard: got out_valid=%b, want 0", out_valid[0]);
    end
    send(0, 9, 4, -2, 3);
    wait_valid(0, n);
    n_cmp++;
    if (n !== 25) begin
      n_err++;
      $display("FAIL midreset_latency: got %0d edges, want 25", n);
    end
    ack(0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      n_real[k] = '0;
      n_imag[k] = '0;
      d_real[k] = '0;
      d_imag[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_dbz();
    test_stall();
    test_saturate();
    test_midreset();
    n_cmp++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d/%0d entries left, want 0/0", sb0.size(), sb1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/complex_divider.md
Name: complex_divider

Overview:
- Sequential fixed-point complex divider: q = n / d = n·conj(d) / |d|².
- The inverse of the team's combinational complex multiplier: same 8-bit signed Re/Im operand format, 16-bit signed results.
- Result carries FRAC_BITS fractional bits.
- Uses iterative restoring division (one quotient bit per cycle per component) behind a valid/ready handshake, for equaliser/normalisation paths downstream of the multiplier.

Parameters:
- FRAC_BITS, 7: fractional bits of the result; legal range 0..8.
- ITER, 16+FRAC_BITS: derived localparam, division iterations (23 at default).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- n_real  in  8  signed numerator real part
- n_imag  in  8  signed numerator imaginary part
- d_real  in  8  signed denominator real part
- d_imag  in  8  signed denominator imaginary part
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q_real  out  16  signed quotient real part, Q(15-FRAC_BITS).FRAC_BITS
- q_imag  out  16  signed quotient imaginary part
- div_by_zero  out  1  result came from a zero denominator
- saturated  out  1  either component was clipped

Behaviour:
- Interface decided: one clock clk; rst is asynchronous, active-high.
- Reset (any time, including mid-division):
  - state=IDLE, in_ready=1, out_valid=0.
  - q_real=q_imag=0, div_by_zero=0, saturated=0.
  - Divider registers and counter cleared; an in-flight operation is discarded with no output.
- FSM states: IDLE, PREP, DIV, FIX, DONE.
  - IDLE: in_ready=1. in_valid&in_ready → latch operands, go to PREP.
  - PREP:
    - num_re = nr·dr + ni·di and num_im = ni·dr − nr·di (17-bit signed).
    - den = dr² + di² (16-bit unsigned; max 32768).
    - den==0 → FIX with dbz flag set.
    - Else load |num_x|<<FRAC_BITS into both dividers, record signs, cnt=0, go to DIV.
  - DIV: one restoring step per edge in both dividers; cnt increments; cnt==ITER−1 → FIX.
  - FIX:
    - Apply sign (truncation toward zero), then saturate to [−32768, +32767].
    - Register q_*, div_by_zero and saturated; out_valid=1; go to DONE.
    - dbz case: q_real=q_imag=0, div_by_zero=1, saturated=0.
  - DONE: outputs held stable while out_valid=1 & out_ready=0. out_ready=1 → out_valid=0, IDLE.
- in_ready=1 only in IDLE; no input accepted while busy. in_valid in any other state is ignored (not queued).
- Latency:
  - Accepting edge N → out_valid high after edge N+ITER+2 (25 edges at default).
  - dbz: out_valid high after edge N+2.
- Throughput: one operation per ITER+4 cycles minimum (IDLE→…→DONE→IDLE).
- Range: |component| ≤ 128, so saturation occurs only when FRAC_BITS=8 and the result is +128.0 (→ +32767, saturated=1).
- Outputs q_*, div_by_zero, saturated are valid only with out_valid. They keep their last values otherwise; do not clear on handshake.

Optional Feature:
- COMPLEX_DIV_ROUND_EN
  - Defined: in FIX, magnitude += 1 when 2·remainder ≥ den (round half away from zero), before sign and saturation. No added latency.
  - Undefined: truncation toward zero; remainder unused.

Decomposition:
- Package complex_div_pkg:
  - state enum (IDLE, PREP, DIV, FIX, DONE)
  - OPW=8, OUTW=16, NUMW=17, DENW=16
  - Q_MAX=16'sh7FFF, Q_MIN=16'sh8000
- Sub-module serial_udiv: unsigned restoring divider with load, step, quotient and remainder outputs, width parameterised. Instantiated twice (real, imag), sharing den.

Test Plan:
- Defaults; (8+0j)/(2+0j) → after 25 edges q_real=512, q_imag=0, div_by_zero=0, saturated=0.
- (1+1j)/(1−1j) → q_real=0, q_imag=128 (exactly j). (1+0j)/(3+0j) → q_real=42 truncated; 43 with COMPLEX_DIV_ROUND_EN.
- (5−7j)/(0+0j) → out_valid 2 edges after accept, q_real=q_imag=0, div_by_zero=1.
- FRAC_BITS=8, (−128+0j)/(−1+0j) → q_real=32767, saturated=1. (−128+0j)/(1+0j) → q_real=−32768, saturated=0.
- Hold out_ready=0 for 10 cycles in DONE with in_valid=1 toggling → outputs stable, in_ready=0, no second capture. Then out_ready=1 → IDLE, next operand accepted.
- Assert rst during DIV (cnt=10) → all outputs reset immediately. Next operation after release produces the correct result with full latency.
